// File: rtl/result_restore.sv
// rtl/result_restore.sv - rebuilds the final IEEE-754 double from sin/cos/sqrt core output
//
// Purpose: takes the raw double from the compute core plus the upstream
// exponent offset (sqrt) or quadrant tag (sin/cos) and produces the final
// result through a fixed IDLE -> CALC -> PACK -> OUT sequence.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle request, accepted only in IDLE
//   mode       - 4=sin, 5=cos, 6=sqrt, anything else passes raw through
//   raw_result - double from the compute core
//   exponent   - sqrt exponent offset, bit10=subtract, bits[9:0]=magnitude
//   quadrant   - sin/cos quadrant tag, 1..4 meaningful
//   result     - restored double, registered
//   done       - one-cycle pulse when result/invalid update
//   busy       - high in every state except IDLE
//   invalid    - set when the canonical quiet NaN was forced
module result_restore #(
    parameter int          EXP_BIAS = 1023,
    parameter logic [63:0] QNAN     = 64'h7FF8000000000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [63:0] raw_result,
    input  logic [10:0] exponent,
    input  logic [2:0]  quadrant,
    output logic [63:0] result,
    output logic        done,
    output logic        busy,
    output logic        invalid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // All-ones biased exponent (Inf/NaN) derived from the bias.
    localparam logic [10:0] EXP_MAX = 11'(2 * EXP_BIAS + 1);
    localparam logic [63:0] POS_INF = {1'b0, EXP_MAX, 52'b0};

    logic [1:0]  state_q, state_d;
    logic [2:0]  mode_q;
    logic [63:0] raw_q;
    logic [10:0] exp_q;
    logic [2:0]  quad_q;
    logic [12:0] sum_q, sum_d;
    logic [63:0] pack_q, pack_d;
    logic        pack_inv_q, pack_inv_d;
    logic [63:0] result_q;
    logic        invalid_q;
    logic        done_q;
    logic        neg;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  state_d = S_PACK;
            S_PACK:  state_d = S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    // 13-bit signed so that both overflow past 2047 and underflow below 1
    // are visible to the PACK stage.
    always_comb begin
        sum_d = {2'b00, raw_q[62:52]};
        if (exp_q[10]) begin
            sum_d = {2'b00, raw_q[62:52]} - {3'b000, exp_q[9:0]};
        end else begin
            sum_d = {2'b00, raw_q[62:52]} + {3'b000, exp_q[9:0]};
        end
    end

    always_comb begin
        pack_d     = raw_q;
        pack_inv_d = 1'b0;
        neg        = 1'b0;
        case (mode_q)
            3'd6: begin
                if (raw_q[62:52] == 11'd0) begin
                    pack_d = {raw_q[63], 63'b0};
                end else if (raw_q[63]) begin
                    pack_d     = QNAN;
                    pack_inv_d = 1'b1;
                end else if (raw_q[62:52] == EXP_MAX) begin
                    pack_d = raw_q;
                end else if (!sum_q[12] && (sum_q >= {2'b00, EXP_MAX})) begin
                    pack_d = POS_INF;
                end else if (sum_q[12] || (sum_q == 13'd0)) begin
                    pack_d = 64'd0;
                end else begin
                    pack_d = {1'b0, sum_q[10:0], raw_q[51:0]};
                end
            end
            3'd4, 3'd5: begin
                // Quadrant tags outside 1..4 leave the core value untouched.
                if ((quad_q >= 3'd1) && (quad_q <= 3'd4)) begin
                    if (mode_q == 3'd4) begin
                        neg = (quad_q == 3'd3) || (quad_q == 3'd4);
                    end else begin
                        neg = (quad_q == 3'd2) || (quad_q == 3'd3);
                    end
                    if (raw_q[62:0] == 63'd0) begin
                        pack_d = 64'd0;
                    end else begin
                        pack_d = {raw_q[63] ^ neg, raw_q[62:0]};
                    end
                end
            end
            default: begin
                pack_d = raw_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 3'd0;
            raw_q      <= 64'd0;
            exp_q      <= 11'd0;
            quad_q     <= 3'd0;
            sum_q      <= 13'd0;
            pack_q     <= 64'd0;
            pack_inv_q <= 1'b0;
            result_q   <= 64'd0;
            invalid_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        raw_q  <= raw_result;
                        exp_q  <= exponent;
                        quad_q <= quadrant;
                    end
                end
                S_CALC: begin
                    if (mode_q == 3'd6) begin
                        sum_q <= sum_d;
                    end
                end
                S_PACK: begin
                    pack_q     <= pack_d;
                    pack_inv_q <= pack_inv_d;
                end
                default: begin
                    result_q  <= pack_q;
                    invalid_q <= pack_inv_q;
                    done_q    <= 1'b1;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign invalid = invalid_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/result_restore.md
Name: result_restore

Overview:
Post-processing stage directly downstream of the operand range-correction stage in the FPU datapath. It takes the raw double-precision result from the sin/cos or square-root core, together with the exponent offset and quadrant tag produced upstream, and rebuilds the final IEEE-754 double. Output goes to the top-level result register with a one-cycle done pulse.

Parameters:
EXP_BIAS, 1023, IEEE-754 double exponent bias (documentation and NaN/Inf encoding only)
QNAN, 64'h7FF8000000000000, canonical quiet NaN emitted on invalid input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; inputs sampled on the edge where start=1 and state=IDLE
mode  input  3  operation: 4=sin, 5=cos, 6=sqrt, 7=pass, others=pass
raw_result  input  64  double from the compute core
exponent  input  11  sqrt exponent offset; bit10=1 means subtract, bits[9:0]=magnitude
quadrant  input  3  sin/cos quadrant tag, valid values 1..4
result  output  64  restored double, registered
done  output  1  one-cycle pulse when result is updated
busy  output  1  high in every state except IDLE
invalid  output  1  registered with result; 1 when QNAN was forced

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, done=0, invalid=0, all internal latches=0. Reset mid-operation aborts the operation with no done pulse.
- FSM states are IDLE, CALC, PACK and OUT.
  - IDLE to CALC on start. Latch mode, raw_result, exponent and quadrant.
  - CALC to PACK, unconditionally.
  - PACK to OUT, unconditionally.
  - OUT to IDLE, unconditionally. done=1 only in the cycle after the OUT edge, so result and done update together.
- Latency: start sampled at edge N, so done=1 and the new result are visible after edge N+3.
- start while busy=1 is ignored. The latched operands are not disturbed.
- result and invalid hold their values until the next done.
- CALC for mode 6: compute sum = {0,raw[62:52]} +/- exponent[9:0] in 13-bit signed arithmetic. Bit10 selects subtraction. Register sum.
- PACK for mode 6, checked in this priority order:
  1. raw[62:52]==0 (zero input): result={raw[63],63'b0}, exponent ignored.
  2. raw[63]==1 (negative non-zero): result=QNAN, invalid=1.
  3. raw[62:52]==11'h7FF (Inf/NaN): pass raw unchanged.
  4. sum>=2047: result=+Inf (64'h7FF0000000000000).
  5. sum<=0: result=+0. Flush to zero; no subnormals are generated.
  6. Otherwise: result={0, sum[10:0], raw[51:0]}.
- PACK for modes 4/5 applies a sign correction. neg=1 when any of these holds:
  - sin and quadrant is 3 or 4
  - cos and quadrant is 2 or 3
- Sign rules for modes 4/5:
  - result={raw[63]^neg, raw[62:0]}.
  - If raw[62:0]==0, the sign is forced to 0 (no -0).
  - quadrant 0 or 5..7: pass raw unchanged, invalid=0.
- All other modes: result=raw_result, invalid=0.
- CALC does nothing in modes other than 6.
- invalid is cleared on every done except in case 2 above.

Test Plan:
- sqrt, scale up: mode=6, raw=64'h3FF8000000000000 (1.5), exponent=11'h002 -> result=64'h4018000000000000 (6.0), done exactly 3 edges after start, invalid=0.
- sqrt, scale down: raw=64'h3FF8000000000000, exponent=11'h402 -> result=64'h3FD8000000000000 (0.375).
- sqrt overflow and underflow:
  - raw=64'h7FE0000000000000, exponent=11'h00A -> 64'h7FF0000000000000.
  - raw=64'h0010000000000000, exponent=11'h405 -> 64'h0.
  - raw=64'hBFF0000000000000 -> 64'h7FF8000000000000, invalid=1.
- sin/cos sign restore, raw=64'h3FE0000000000000:
  - sin, quadrant 4 -> 64'hBFE0000000000000.
  - cos, quadrant 4 -> 64'h3FE0000000000000.
  - cos, quadrant 2 -> 64'hBFE0000000000000.
  - sin, quadrant 4 with raw=0 -> 64'h0.
- Handshake: a second start one cycle after the first is ignored. Exactly one done, carrying the first operands. busy=1 for 3 cycles.
- Reset mid-op: assert rst_n=0 during PACK -> result=0 immediately, no done pulse. A subsequent start completes normally.
